// File: rtl/fetch_pkg.sv
// Shared types for the IF-stage fetch controller: FSM states, redirect kinds, NOP encoding.
// No logic here beyond the redirect priority rule.
// Used by fetch_ctrl and fetch_redirect_latch.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      BR   = 2'd1,
      TRAP = 2'd2
   } redir_kind_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // A new trap always wins; a new branch wins unless a trap is already pending.
   function automatic logic redir_takes_over(input redir_kind_t incoming,
                                             input redir_kind_t pending);
      return (incoming == TRAP) || ((incoming == BR) && (pending != TRAP));
   endfunction

endpackage

// File: rtl/fetch_redirect_latch.sv
// Merges this cycle's branch/trap request with the pending one and remembers it until the fetch completes.
// Latency: redirect visible combinationally the same cycle; pending state updates on posedge.
// Backpressure: none; capture/clear strobes come from the fetch FSM.
module fetch_redirect_latch
   import fetch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic            capture_i,
   input  logic            clear_i,
   output logic            redir_vld_o,
   output logic [XLEN-1:0] redir_tgt_o
);

   redir_kind_t     pend_kind_q;
   redir_kind_t     in_kind;
   redir_kind_t     eff_kind;
   logic [XLEN-1:0] pend_tgt_q;
   logic [XLEN-1:0] in_tgt;
   logic [XLEN-1:0] eff_tgt;

   always_comb begin
      in_kind = NONE;
      in_tgt  = br_target_i;
      if (trap_valid_i) begin
         in_kind = TRAP;
         in_tgt  = mtvec_i;
      end else if (br_valid_i) begin
         in_kind = BR;
      end
      eff_kind = pend_kind_q;
      eff_tgt  = pend_tgt_q;
      if (redir_takes_over(in_kind, pend_kind_q)) begin
         eff_kind = in_kind;
         eff_tgt  = in_tgt;
      end
   end

   assign redir_vld_o = (eff_kind != NONE);
   assign redir_tgt_o = eff_tgt & ~XLEN'(3);

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_kind_q <= NONE;
         pend_tgt_q  <= '0;
      end else if (clear_i) begin
         pend_kind_q <= NONE;
      end else if (capture_i) begin
         pend_kind_q <= eff_kind;
         pend_tgt_q  <= eff_tgt;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: picks next PC (trap > branch > PC+4), runs imem req/ack, presents {pc, instr}.
// Latency: ack at edge N gives if_valid_o after edge N+1.
// Backpressure: stall_i at ack parks the instruction in HOLD until stall_i drops or a redirect arrives.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   output logic            pc_ld_o,
   output logic [XLEN-1:0] pc_next_o,
   input  logic            stall_i,
   input  logic            br_valid_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] mtvec_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [31:0]     if_instr_o
);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic            redir_vld;
   logic [XLEN-1:0] redir_tgt;
   logic            redir_cap;
   logic            redir_clr;
   logic            valid_d;
   logic [XLEN-1:0] pc_d;
   logic [31:0]     instr_d;
   logic [XLEN-1:0] pc_plus4;

   // Wraps modulo 2^XLEN by construction.
   assign pc_plus4    = (pc_i + XLEN'(4)) & ~XLEN'(3);
   assign imem_addr_o = pc_i;

   fetch_redirect_latch #(
      .XLEN (XLEN)
   ) u_redirect (
      .clk          (clk),
      .rst          (rst),
      .br_valid_i   (br_valid_i),
      .br_target_i  (br_target_i),
      .trap_valid_i (trap_valid_i),
      .mtvec_i      (mtvec_i),
      .capture_i    (redir_cap),
      .clear_i      (redir_clr),
      .redir_vld_o  (redir_vld),
      .redir_tgt_o  (redir_tgt)
   );

   always_comb begin
      state_d    = state_q;
      pc_ld_o    = 1'b0;
      pc_next_o  = pc_plus4;
      imem_req_o = 1'b0;
      redir_cap  = 1'b0;
      redir_clr  = 1'b0;
      valid_d    = 1'b0;
      pc_d       = if_pc_o;
      instr_d    = if_instr_o;
      case (state_q)
         BOOT: begin
            pc_ld_o   = 1'b1;
            pc_next_o = RESET_VEC & ~XLEN'(3);
            redir_cap = 1'b1;
            state_d   = REQ;
         end
         REQ: begin
            imem_req_o = 1'b1;
            if (!imem_ack_i) begin
               redir_cap = 1'b1;
            end else begin
               redir_clr = 1'b1;
               if (redir_vld) begin
                  // Data fetched down the old path is dropped.
                  pc_ld_o   = 1'b1;
                  pc_next_o = redir_tgt;
               end else begin
                  valid_d = 1'b1;
                  pc_d    = pc_i;
                  instr_d = imem_rdata_i;
                  if (stall_i) state_d = HOLD;
                  else         pc_ld_o = 1'b1;
               end
            end
         end
         HOLD: begin
            valid_d = 1'b1;
            if (redir_vld) begin
               pc_ld_o   = 1'b1;
               pc_next_o = redir_tgt;
               valid_d   = 1'b0;
               state_d   = REQ;
            end else if (!stall_i) begin
               pc_ld_o = 1'b1;
               valid_d = 1'b0;
               state_d = REQ;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         if_valid_o <= 1'b0;
         if_pc_o    <= '0;
         if_instr_o <= NOP_INSTR;
      end else begin
         state_q    <= state_d;
         if_valid_o <= valid_d;
         if_pc_o    <= pc_d;
         if_instr_o <= instr_d;
      end
   end

endmodule
